// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared types and constants for the FIFO read-side stream adapter
package fifo_rd_stream_pkg;

    typedef enum logic [0:0] {
        STREAM = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

    // A read may issue only if the buffer, after this cycle's write and pop,
    // still has a free slot for the word that returns next cycle.
    function automatic logic room_for_read(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [OCC_W:0] fill;
        fill = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
        return fill <= {{OCC_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - valid/ready output stream of the FIFO read adapter
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - two-entry register skid buffer with write, pop and clear
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clr) begin
            occ <= '0;
        end else begin
            case ({wr, pop})
                2'b10: begin
                    if (occ == '0) begin
                        head_q <= wr_data;
                    end else begin
                        tail_q <= wr_data;
                    end
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - OCC_W'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever stays.
                    if (occ == OCC_W'(SKID_DEPTH)) begin
                        head_q <= tail_q;
                        tail_q <= wr_data;
                    end else begin
                        head_q <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain to valid/ready stream with flush; FIFO_RD_STATS_EN adds word_cnt
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    fifo_rd_stream_if.master      m_axis,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  flush_done
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic             rd_en;
    logic             buf_wr;
    logic             buf_clr;
    logic             done_nxt;
    logic             flush_done_q;

    assign pop            = m_axis.m_valid & m_axis.m_ready;
    assign m_axis.m_valid = (occ != '0);

    fifo_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .wr     (buf_wr),
        .wr_data(fifo_data),
        .pop    (pop),
        .occ    (occ),
        .head   (m_axis.m_data)
    );

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        buf_wr    = 1'b0;
        buf_clr   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            STREAM: begin
                rd_en  = !fifo_empty && room_for_read(occ, inflight, pop);
                buf_wr = inflight;
                if (flush) begin
                    buf_clr   = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Keep draining; returning words never reach the buffer.
                rd_en = !fifo_empty;
                if (fifo_empty && !inflight) begin
                    state_nxt = STREAM;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = STREAM;
        endcase
        if (rst) begin
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= STREAM;
            inflight     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            inflight     <= rd_en;
            flush_done_q <= done_nxt;
        end
    end

    assign fifo_rd_en = rd_en;
    assign flush_busy = (state == FLUSH);
    assign flush_done = flush_done_q;

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_word_cnt;
    assign unused_word_cnt = '0;
`endif

    occ_bounded: assert property (@(posedge clk) disable iff (rst) occ <= OCC_W'(SKID_DEPTH));
    no_read_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream against a queue model
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          flush;
    logic          flush_busy;
    logic          flush_done;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]   word_cnt;
`endif

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .m_axis    (s_if),
        .flush     (flush),
        .flush_busy(flush_busy),
        .flush_done(flush_done)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            cyc = 0;
    int            s_cyc;
    logic          s_rd, s_v, s_pop, s_done, s_busy, s_rst;
    logic [DW-1:0] s_data;
    int            pop_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int            outstanding = 0, max_out = 0;
    int            first_pop, last_pop;

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample away from the edge, score pops, then advance the FIFO model.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        s_cyc  = cyc;
        s_rst  = rst;
        s_rd   = fifo_rd_en;
        s_v    = s_if.m_valid;
        s_data = s_if.m_data;
        s_done = flush_done;
        s_busy = flush_busy;
        s_pop  = s_v && s_if.m_ready && !rst;
        check_val("rd_while_empty", 32'(s_rd & fifo_empty), 0);
        if (s_pop) begin
            check_val("pop_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("pop_data", 32'(s_data), 32'(e));
            end
            pop_cnt++;
            if (first_pop < 0) first_pop = s_cyc;
            last_pop = s_cyc;
        end
        if (s_done) done_cnt++;
        if (s_rd) rd_cnt++;
        outstanding += int'(s_rd) - int'(s_pop);
        if (outstanding > max_out) max_out = outstanding;
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        if (s_rst) begin
            // Anything already pulled out of the FIFO is lost on reset.
            exp_q       = fifo_q;
            outstanding = 0;
        end
        cyc++;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || s_if.m_valid) && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int n0, first_v, pc0, rc0, dc0, sent, n;

        rst        = 1'b1;
        flush      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        s_if.m_ready = 1'b0;
        first_pop  = -1;
        last_pop   = -1;

        tick();
        tick();
        check_val("rst_rd_en", 32'(s_rd), 0);
        rst = 1'b0;
        tick();
        check_val("rst_m_valid", 32'(s_v), 0);
        check_val("rst_m_data", 32'(s_data), 0);
        check_val("rst_flush_busy", 32'(s_busy), 0);
        check_val("rst_flush_done", 32'(s_done), 0);
`ifdef FIFO_RD_STATS_EN
        check_val("rst_word_cnt", 32'(word_cnt), 0);
`endif

        // Idle with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("idle_rd_en", 32'(s_rd), 0);
            check_val("idle_m_valid", 32'(s_v), 0);
            check_val("idle_flush_done", 32'(s_done), 0);
        end

        // Preloaded burst at full rate.
        s_if.m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(DW'(i));
        n0 = cyc; first_v = -1; pc0 = pop_cnt; first_pop = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_v && first_v < 0) first_v = s_cyc;
        end
        check_val("burst_latency", 32'(first_v - n0), 2);
        check_val("burst_count", 32'(pop_cnt - pc0), 16);
        check_val("burst_span", 32'(last_pop - first_pop), 15);
        check_val("burst_left", 32'(exp_q.size()), 0);
`ifdef FIFO_RD_STATS_EN
        check_val("burst_word_cnt", 32'(word_cnt), 16);
`endif

        // Back-pressure holds two words and the head stays put.
        s_if.m_ready = 1'b0;
        rc0 = rd_cnt;
        for (int i = 0; i < 8; i++) push(DW'(8'hA0 + i));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_v) check_val("bp_hold", 32'(s_data), 32'h0A0);
        end
        check_val("bp_reads", 32'(rd_cnt - rc0), 2);
        check_val("bp_valid", 32'(s_v), 1);
        s_if.m_ready = 1'b1;
        pc0 = pop_cnt; first_pop = -1;
        for (int i = 0; i < 12; i++) tick();
        check_val("bp_count", 32'(pop_cnt - pc0), 8);
        check_val("bp_span", 32'(last_pop - first_pop), 7);
        check_val("bp_left", 32'(exp_q.size()), 0);

        // Random ready and random FIFO arrivals.
        max_out = outstanding; pc0 = pop_cnt; sent = 0; n = 0;
        while ((sent < 256 || exp_q.size() > 0 || s_if.m_valid) && n < 5000) begin
            s_if.m_ready = 1'($urandom_range(0, 1));
            if (sent < 256 && $urandom_range(0, 1) == 1) begin
                push(DW'($urandom_range(0, 255)));
                sent++;
            end
            tick();
            n++;
        end
        check_val("rand_left", 32'(exp_q.size()), 0);
        check_val("rand_count", 32'(pop_cnt - pc0), 256);
        check_val("rand_max_held", 32'(max_out <= 2), 1);

        // Flush with five words split between buffer and FIFO; the flush-cycle pop still lands.
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(DW'(8'h30 + i));
        for (int i = 0; i < 4; i++) tick();
        s_if.m_ready = 1'b1;
        pc0 = pop_cnt;
        flush = 1'b1;
        tick();
        check_val("flush_cycle_pop", 32'(pop_cnt - pc0), 1);
        exp_q.delete();
        flush = 1'b0;
        dc0 = done_cnt;
        tick();
        check_val("flush_m_valid", 32'(s_v), 0);
        check_val("flush_busy", 32'(s_busy), 1);
        n = 0;
        while (!s_done && n < 50) begin
            tick();
            n++;
        end
        check_val("flush_done_seen", 32'(s_done), 1);
        check_val("flush_busy_at_done", 32'(s_busy), 0);
        check_val("flush_fifo_empty", 32'(fifo_q.size()), 0);
        for (int i = 0; i < 5; i++) tick();
        check_val("flush_done_once", 32'(done_cnt - dc0), 1);
        pc0 = pop_cnt;
        push(8'h55);
        drain(20, "post_flush");
        check_val("post_flush_count", 32'(pop_cnt - pc0), 1);

        // Reset while a read is in flight and a word is buffered.
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DW'(8'h60 + i));
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_rd_en", 32'(s_rd), 0);
        rst = 1'b0;
        tick();
        check_val("mid_rst_m_valid", 32'(s_v), 0);
        check_val("mid_rst_m_data", 32'(s_data), 0);
        check_val("mid_rst_busy", 32'(s_busy), 0);
        check_val("mid_rst_done", 32'(s_done), 0);
`ifdef FIFO_RD_STATS_EN
        check_val("mid_rst_word_cnt", 32'(word_cnt), 0);
`endif
        s_if.m_ready = 1'b1;
        pc0 = pop_cnt;
        drain(40, "post_rst");
        check_val("post_rst_count", 32'(pop_cnt - pc0), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
